// File: rtl/conv_pe_sequencer_pkg.sv
// Shared types for the convolution PE sequencer: FSM states, ternary tap type, width helper.
package conv_pe_sequencer_pkg;

  localparam int TAP_W = 2;

  typedef logic signed [TAP_W-1:0] tap_t;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    DRAIN,
    EMIT,
    DONE
  } seq_state_t;

  // Address/counter width that never collapses to zero bits.
  function automatic int aw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_pe_sequencer_if.sv
// Bundle of the sequencer's control, ifmap/weight read and ofmap stream signals.
// master = sequencer side, slave = buffers / ofmap writer / controller side.
interface conv_pe_sequencer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int K          = 3,
  parameter int ZC_W       = 16
);
  import conv_pe_sequencer_pkg::*;

  localparam int IF_AW = aw(IMG_W * IMG_H);
  localparam int WT_AW = aw(K * K);
  localparam int OF_AW = aw((IMG_W - K + 1) * (IMG_H - K + 1));

  logic                         start;
  logic                         busy;
  logic                         done;
  logic                         ifmap_rd_en;
  logic [IF_AW-1:0]             ifmap_addr;
  tap_t                         ifmap_rd_data;
  logic                         wt_rd_en;
  logic [WT_AW-1:0]             wt_addr;
  tap_t                         wt_rd_data;
  logic                         ofmap_valid;
  logic                         ofmap_ready;
  logic signed [DATA_WIDTH-1:0] ofmap_data;
  logic [OF_AW-1:0]             ofmap_addr;
  logic [ZC_W-1:0]              zero_tap_count;

  modport master (
    input  start, ifmap_rd_data, wt_rd_data, ofmap_ready,
    output busy, done, ifmap_rd_en, ifmap_addr, wt_rd_en, wt_addr,
           ofmap_valid, ofmap_data, ofmap_addr, zero_tap_count
  );

  modport slave (
    output start, ifmap_rd_data, wt_rd_data, ofmap_ready,
    input  busy, done, ifmap_rd_en, ifmap_addr, wt_rd_en, wt_addr,
           ofmap_valid, ofmap_data, ofmap_addr, zero_tap_count
  );

endinterface

// File: rtl/conv_pe_sequencer_pe.sv
// Ternary multiply-accumulate PE: outpsum = inpsum + weight * infmap_value, wrapping.
// Purely combinational; no handshake.
module conv_pe_sequencer_pe
  import conv_pe_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic signed [DATA_WIDTH-1:0] inpsum,
  input  tap_t                         weight,
  input  tap_t                         infmap_value,
  output logic signed [DATA_WIDTH-1:0] outpsum
);

  logic signed [DATA_WIDTH-1:0] w_ext;
  logic signed [DATA_WIDTH-1:0] i_ext;

  // Sign-extend before multiplying so the product wraps in the psum width.
  assign w_ext   = DATA_WIDTH'(weight);
  assign i_ext   = DATA_WIDTH'(infmap_value);
  assign outpsum = inpsum + w_ext * i_ext;

endmodule

// File: rtl/conv_pe_sequencer.sv
// Sequences one PE through a KxK stride-1 convolution, streaming one psum per output pixel.
// Latency K*K+2 cycles per pixel; backpressure holds EMIT with no reads until ofmap_ready.
module conv_pe_sequencer
  import conv_pe_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int K          = 3,
  parameter int ZC_W       = 16
) (
  input logic                 clk,
  input logic                 reset,
  conv_pe_sequencer_if.master bus
);

  localparam int OUT_W = IMG_W - K + 1;
  localparam int OUT_H = IMG_H - K + 1;
  localparam int IF_AW = aw(IMG_W * IMG_H);
  localparam int WT_AW = aw(K * K);
  localparam int OF_AW = aw(OUT_W * OUT_H);
  localparam int KC_W  = aw(K);
  localparam int CC_W  = aw(OUT_W);
  localparam int RC_W  = aw(OUT_H);

  localparam logic [KC_W-1:0] K_LAST   = KC_W'(K - 1);
  localparam logic [CC_W-1:0] COL_LAST = CC_W'(OUT_W - 1);
  localparam logic [RC_W-1:0] ROW_LAST = RC_W'(OUT_H - 1);

  seq_state_t                   state;
  logic [KC_W-1:0]              kx, ky;
  logic [CC_W-1:0]              col;
  logic [RC_W-1:0]              row;
  logic signed [DATA_WIDTH-1:0] psum_q;
  logic signed [DATA_WIDTH-1:0] pe_out;
  logic                         rd_en_q;
  logic                         rd_valid_q;
  logic                         busy_q;
  logic                         done_q;
  logic                         valid_q;
  logic [ZC_W-1:0]              zc_q;

  conv_pe_sequencer_pe #(.DATA_WIDTH(DATA_WIDTH)) u_pe (
    .inpsum       (psum_q),
    .weight       (bus.wt_rd_data),
    .infmap_value (bus.ifmap_rd_data),
    .outpsum      (pe_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      valid_q    <= 1'b0;
      kx         <= '0;
      ky         <= '0;
      col        <= '0;
      row        <= '0;
      psum_q     <= '0;
      zc_q       <= '0;
    end else begin
      // Read data returns one cycle after the strobe; accumulate it then.
      rd_valid_q <= rd_en_q;
      done_q     <= 1'b0;
      if (rd_valid_q) begin
        psum_q <= pe_out;
        if (bus.ifmap_rd_data == '0 && zc_q != '1) begin
          zc_q <= zc_q + ZC_W'(1);
        end
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= ACCUM;
            busy_q  <= 1'b1;
            rd_en_q <= 1'b1;
            kx      <= '0;
            ky      <= '0;
            col     <= '0;
            row     <= '0;
            psum_q  <= '0;
            zc_q    <= '0;
          end
        end
        ACCUM: begin
          if (kx == K_LAST) begin
            kx <= '0;
            if (ky == K_LAST) begin
              ky      <= '0;
              rd_en_q <= 1'b0;
              state   <= DRAIN;
            end else begin
              ky <= ky + KC_W'(1);
            end
          end else begin
            kx <= kx + KC_W'(1);
          end
        end
        DRAIN: begin
          valid_q <= 1'b1;
          state   <= EMIT;
        end
        EMIT: begin
          if (bus.ofmap_ready) begin
            valid_q <= 1'b0;
            psum_q  <= '0;
            if (col == COL_LAST) begin
              col <= '0;
              if (row == ROW_LAST) begin
                row    <= '0;
                done_q <= 1'b1;
                state  <= DONE;
              end else begin
                row     <= row + RC_W'(1);
                rd_en_q <= 1'b1;
                state   <= ACCUM;
              end
            end else begin
              col     <= col + CC_W'(1);
              rd_en_q <= 1'b1;
              state   <= ACCUM;
            end
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.ifmap_rd_en    = rd_en_q;
  assign bus.wt_rd_en       = rd_en_q;
  assign bus.ifmap_addr     = IF_AW'((32'(row) + 32'(ky)) * 32'(IMG_W) + 32'(col) + 32'(kx));
  assign bus.wt_addr        = WT_AW'(32'(ky) * 32'(K) + 32'(kx));
  assign bus.ofmap_valid    = valid_q;
  assign bus.ofmap_data     = psum_q;
  assign bus.ofmap_addr     = OF_AW'(32'(row) * 32'(OUT_W) + 32'(col));
  assign bus.zero_tap_count = zc_q;

endmodule

// File: tb/tb_conv_pe_sequencer.sv
// Scoreboard bench: two sequencers (8-bit and 4-bit psum) on a 4x4 map with K=3.
module tb_conv_pe_sequencer;

  localparam int IW   = 4;
  localparam int IH   = 4;
  localparam int KK   = 3;
  localparam int OW   = IW - KK + 1;
  localparam int OH   = IH - KK + 1;
  localparam int NPIX = OW * OH;
  localparam int LAT  = NPIX * (KK * KK + 2) + 1;

  typedef struct {
    int addr;
    int data;
  } pix_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  pix_t qa[$];
  pix_t qb[$];
  int   exp_zc[2];
  int   stall[2];
  int   start_cyc[2];
  bit   done_seen[2];

  logic signed [1:0] ifmem[IW*IH];
  logic signed [1:0] wtmem[KK*KK];

  conv_pe_sequencer_if #(.DATA_WIDTH(8), .IMG_W(IW), .IMG_H(IH), .K(KK), .ZC_W(16)) ifa ();
  conv_pe_sequencer_if #(.DATA_WIDTH(4), .IMG_W(IW), .IMG_H(IH), .K(KK), .ZC_W(16)) ifb ();

  conv_pe_sequencer #(.DATA_WIDTH(8), .IMG_W(IW), .IMG_H(IH), .K(KK), .ZC_W(16)) u_a (
    .clk(clk), .reset(reset), .bus(ifa));
  conv_pe_sequencer #(.DATA_WIDTH(4), .IMG_W(IW), .IMG_H(IH), .K(KK), .ZC_W(16)) u_b (
    .clk(clk), .reset(reset), .bus(ifb));

  // Global buffers: synchronous read, one cycle latency.
  always @(posedge clk) begin
    if (ifa.ifmap_rd_en) ifa.ifmap_rd_data <= ifmem[ifa.ifmap_addr];
    if (ifa.wt_rd_en)    ifa.wt_rd_data    <= wtmem[ifa.wt_addr];
    if (ifb.ifmap_rd_en) ifb.ifmap_rd_data <= ifmem[ifb.ifmap_addr];
    if (ifb.wt_rd_en)    ifb.wt_rd_data    <= wtmem[ifb.wt_addr];
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic int wrap(input int s, input int dw);
    int m;
    m = s & ((1 << dw) - 1);
    if (m >= (1 << (dw - 1))) m -= (1 << dw);
    return m;
  endfunction

  task automatic fill(input int iv, input int wv);
    for (int i = 0; i < IW*IH; i++) ifmem[i] = 2'(iv);
    for (int i = 0; i < KK*KK; i++) wtmem[i] = 2'(wv);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < IW*IH; i++) ifmem[i] = 2'(int'($urandom_range(0, 2)) - 1);
    for (int i = 0; i < KK*KK; i++) wtmem[i] = 2'(int'($urandom_range(0, 2)) - 1);
  endtask

  // Reference: direct valid-region convolution over the buffer contents.
  task automatic expect_map(input int dut);
    int dw, zc, s, iv;
    pix_t p;
    dw = (dut == 0) ? 8 : 4;
    zc = 0;
    for (int r = 0; r < OH; r++) begin
      for (int c = 0; c < OW; c++) begin
        s = 0;
        for (int ky = 0; ky < KK; ky++) begin
          for (int kx = 0; kx < KK; kx++) begin
            iv = int'(ifmem[(r + ky) * IW + c + kx]);
            s += iv * int'(wtmem[ky * KK + kx]);
            if (iv == 0) zc++;
          end
        end
        p.addr = r * OW + c;
        p.data = wrap(s, dw);
        if (dut == 0) qa.push_back(p);
        else qb.push_back(p);
      end
    end
    exp_zc[dut] = zc;
  endtask

  task automatic set_start(input int dut, input bit v);
    if (dut == 0) ifa.start = v;
    else ifb.start = v;
  endtask

  task automatic set_ready(input int dut, input bit v);
    if (dut == 0) ifa.ofmap_ready = v;
    else ifb.ofmap_ready = v;
  endtask

  // mode 0: ready held high; 1: random ready; 2: ready low for the first 5 EMIT cycles.
  task automatic run(input int dut, input int mode);
    int t = 0;
    expect_map(dut);
    stall[dut]     = 0;
    done_seen[dut] = 1'b0;
    set_ready(dut, mode == 0 || (mode == 1 && $urandom_range(0, 1) == 1));
    set_start(dut, 1'b1);
    start_cyc[dut] = cyc;
    @(posedge clk) #1;
    set_start(dut, 1'b0);
    while (!done_seen[dut] && t < 2000) begin
      if (mode == 1) set_ready(dut, $urandom_range(0, 1) == 1);
      if (mode == 2) set_ready(dut, stall[dut] >= 5);
      set_start(dut, t == 17);
      @(posedge clk) #1;
      t++;
    end
    set_start(dut, 1'b0);
    if (!done_seen[dut]) fail($sformatf("run_timeout dut=%0d", dut));
    set_ready(dut, 1'b1);
  endtask

  task automatic check_idle_a(input string tag);
    chk({tag, "_busy"},  int'(ifa.busy), 0);
    chk({tag, "_valid"}, int'(ifa.ofmap_valid), 0);
    chk({tag, "_rd_en"}, int'(ifa.ifmap_rd_en | ifa.wt_rd_en), 0);
    chk({tag, "_zc"},    int'(ifa.zero_tap_count), 0);
    chk({tag, "_other"}, int'(|{ifa.done, ifa.ifmap_addr, ifa.wt_addr, ifa.ofmap_data, ifa.ofmap_addr}), 0);
  endtask

  // Monitors: pop expected pixel on each handshake, check hold stability and done.
  logic hold_a = 1'b0;
  int   hold_addr_a, hold_data_a;
  always @(negedge clk) begin
    if (reset) begin
      hold_a = 1'b0;
    end else begin
      if (hold_a) begin
        chk("a_hold_valid", int'(ifa.ofmap_valid), 1);
        chk("a_hold_addr",  int'(ifa.ofmap_addr), hold_addr_a);
        chk("a_hold_data",  int'(ifa.ofmap_data), hold_data_a);
        chk("a_hold_rd_en", int'(ifa.ifmap_rd_en), 0);
      end
      if (ifa.ofmap_valid && ifa.ofmap_ready) begin
        if (qa.size() == 0) fail("a_unexpected_pixel");
        else begin
          pix_t p;
          p = qa.pop_front();
          chk("a_ofmap_addr", int'(ifa.ofmap_addr), p.addr);
          chk("a_ofmap_data", int'(ifa.ofmap_data), p.data);
        end
      end
      hold_a      = ifa.ofmap_valid && !ifa.ofmap_ready;
      hold_addr_a = int'(ifa.ofmap_addr);
      hold_data_a = int'(ifa.ofmap_data);
      if (hold_a) stall[0]++;
      if (ifa.done) begin
        done_seen[0] = 1'b1;
        chk("a_done_latency", cyc - start_cyc[0], LAT + stall[0]);
        chk("a_zero_count",   int'(ifa.zero_tap_count), exp_zc[0]);
        chk("a_pixels_left",  qa.size(), 0);
      end
    end
  end

  logic hold_b = 1'b0;
  int   hold_addr_b, hold_data_b;
  always @(negedge clk) begin
    if (reset) begin
      hold_b = 1'b0;
    end else begin
      if (hold_b) begin
        chk("b_hold_valid", int'(ifb.ofmap_valid), 1);
        chk("b_hold_addr",  int'(ifb.ofmap_addr), hold_addr_b);
        chk("b_hold_data",  int'(ifb.ofmap_data), hold_data_b);
      end
      if (ifb.ofmap_valid && ifb.ofmap_ready) begin
        if (qb.size() == 0) fail("b_unexpected_pixel");
        else begin
          pix_t p;
          p = qb.pop_front();
          chk("b_ofmap_addr", int'(ifb.ofmap_addr), p.addr);
          chk("b_ofmap_data", int'(ifb.ofmap_data), p.data);
        end
      end
      hold_b      = ifb.ofmap_valid && !ifb.ofmap_ready;
      hold_addr_b = int'(ifb.ofmap_addr);
      hold_data_b = int'(ifb.ofmap_data);
      if (hold_b) stall[1]++;
      if (ifb.done) begin
        done_seen[1] = 1'b1;
        chk("b_done_latency", cyc - start_cyc[1], LAT + stall[1]);
        chk("b_zero_count",   int'(ifb.zero_tap_count), exp_zc[1]);
        chk("b_pixels_left",  qb.size(), 0);
      end
    end
  end

  initial begin
    int t;
    ifa.start = 1'b0; ifa.ofmap_ready = 1'b1; ifa.ifmap_rd_data = '0; ifa.wt_rd_data = '0;
    ifb.start = 1'b0; ifb.ofmap_ready = 1'b1; ifb.ifmap_rd_data = '0; ifb.wt_rd_data = '0;
    fill(1, 1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_idle_a("reset_a");
    chk("reset_b_any", int'(|{ifb.busy, ifb.done, ifb.ifmap_rd_en, ifb.wt_rd_en, ifb.ofmap_valid,
                               ifb.ifmap_addr, ifb.wt_addr, ifb.ofmap_data, ifb.ofmap_addr,
                               ifb.zero_tap_count}), 0);
    chk("reset_b_busy", int'(ifb.busy), 0);
    @(posedge clk) #1;

    fill(1, 1);  run(0, 0);   // all +1: data 9
    fill(0, 1);  run(0, 0);   // zero infmap: 36 zero taps
    fill(1, -1); run(0, 0);   // -9
    fill(1, 1);  run(1, 0);   // 4-bit psum: 9 wraps to -7
    fill(1, 1);  run(0, 2);   // 5-cycle stall on first EMIT

    // Reset during the second pixel's accumulation, then a clean rerun.
    fill(1, 1);
    expect_map(0);
    set_ready(0, 1'b1);
    set_start(0, 1'b1);
    start_cyc[0] = cyc;
    @(posedge clk) #1;
    set_start(0, 1'b0);
    t = 0;
    while (qa.size() > NPIX - 1 && t < 200) begin
      @(posedge clk) #1;
      t++;
    end
    if (t >= 200) fail("reset_test_first_pixel_timeout");
    repeat (2) @(posedge clk) #1;
    chk("reset_test_in_accum", int'(ifa.ifmap_rd_en), 1);
    reset = 1'b1;
    @(posedge clk) #1;
    reset = 1'b0;
    check_idle_a("midrun_reset");
    qa.delete();
    run(0, 0);

    for (int n = 0; n < 10; n++) begin
      fill_rand();
      run(n % 2, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
